// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Safety checker sitting between the intersection controller and the lamp
// drivers. Each cycle it classifies the NS/EW lamp buses, tracks the phase
// rotation and the dwell time of every phase. Any violation latches a sticky
// fault with a code and raises force_red (fail-safe all-red request).
//
// Optional build feature (macro TRAFFIC_MON_FAULT_CNT_EN):
//   adds output fault_cnt, a saturating count of FAULT entries that only
//   rst clears. With the macro undefined the port and its logic are absent.

module traffic_light_monitor #(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned GREEN_DWELL  = 50_000_001,
    parameter int unsigned YELLOW_DWELL = 10_000_001,
    parameter int unsigned TOL          = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  ns,
    input  logic [2:0]  ew,
    input  logic        fault_clr,
    output logic [1:0]  phase,
    output logic        phase_valid,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic        force_red,
    output logic [15:0] cycle_cnt
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    ,
    output logic [7:0]  fault_cnt
`endif
);

    // ------------------------------------------------------------------
    // Lamp encodings {red, yellow, green}
    // ------------------------------------------------------------------
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    // Fault codes; lower value means higher priority
    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_CONFLICT = 3'd1;
    localparam logic [2:0] FC_ILLEGAL  = 3'd2;
    localparam logic [2:0] FC_SEQUENCE = 3'd3;
    localparam logic [2:0] FC_SHORT    = 3'd4;
    localparam logic [2:0] FC_LONG     = 3'd5;

    // Dwell windows. The lower bound is clamped at 1 so a tolerance larger
    // than the dwell never wraps the unsigned subtraction.
    localparam logic [CNT_W-1:0] DW_ONE_C    = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] DW_MAX_C    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GREEN_HI_C  = CNT_W'(GREEN_DWELL + TOL);
    localparam logic [CNT_W-1:0] YELLOW_HI_C = CNT_W'(YELLOW_DWELL + TOL);
    localparam logic [CNT_W-1:0] GREEN_LO_C  = (GREEN_DWELL > TOL) ?
                                               CNT_W'(GREEN_DWELL - TOL) : DW_ONE_C;
    localparam logic [CNT_W-1:0] YELLOW_LO_C = (YELLOW_DWELL > TOL) ?
                                               CNT_W'(YELLOW_DWELL - TOL) : DW_ONE_C;

    typedef enum logic [1:0] {
        ST_ACQUIRE     = 2'd0,
        ST_TRACK_FIRST = 2'd1,
        ST_TRACK       = 2'd2,
        ST_FAULT       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // A bus is well formed when exactly one of its three lamps is lit.
    function automatic logic lamp_is_legal(input logic [2:0] lamp);
        logic ok;
        case (lamp)
            LAMP_RED: ok = 1'b1;
            LAMP_YEL: ok = 1'b1;
            LAMP_GRN: ok = 1'b1;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    // A bus lets traffic move when it shows green or yellow.
    function automatic logic lamp_is_go(input logic [2:0] lamp);
        logic go;
        case (lamp)
            LAMP_YEL: go = 1'b1;
            LAMP_GRN: go = 1'b1;
            default:  go = 1'b0;
        endcase
        return go;
    endfunction

    // Phase decode for a pair already known to be legal and non-conflicting.
    function automatic logic [1:0] decode_phase(input logic [2:0] ns_l,
                                                input logic [2:0] ew_l);
        logic [1:0] p;
        case ({ns_l, ew_l})
            {LAMP_GRN, LAMP_RED}: p = 2'd0;
            {LAMP_YEL, LAMP_RED}: p = 2'd1;
            {LAMP_RED, LAMP_GRN}: p = 2'd2;
            {LAMP_RED, LAMP_YEL}: p = 2'd3;
            default:              p = 2'd0;
        endcase
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Registers and next-state signals
    // ------------------------------------------------------------------
    state_t           state_q,       state_d;
    logic [1:0]       phase_q,       phase_d;
    logic             phase_valid_q, phase_valid_d;
    logic             fault_q,       fault_d;
    logic [2:0]       fault_code_q,  fault_code_d;
    logic             force_red_q,   force_red_d;
    logic [15:0]      cycle_cnt_q,   cycle_cnt_d;
    logic [CNT_W-1:0] dwell_cnt_q,   dwell_cnt_d;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    logic [7:0]       fault_cnt_q,   fault_cnt_d;
`endif

    logic             conflict_s;
    logic             illegal_s;
    logic [1:0]       p_s;
    logic [1:0]       next_phase_s;
    logic [CNT_W-1:0] dw_hi_s;
    logic [CNT_W-1:0] dw_lo_s;
    logic [2:0]       viol_code_s;
    logic             fault_entry_s;

    // Classify the raw lamp buses: conflict, illegal encoding, or a phase.
    always_comb begin
        conflict_s = lamp_is_go(ns) && lamp_is_go(ew);
        illegal_s  = !lamp_is_legal(ns) || !lamp_is_legal(ew) ||
                     ((ns == LAMP_RED) && (ew == LAMP_RED));
        p_s        = decode_phase(ns, ew);
    end

    // Dwell window and expected successor of the phase currently held.
    always_comb begin
        next_phase_s = phase_q + 2'd1;
        if (phase_q[0] == 1'b0) begin
            dw_hi_s = GREEN_HI_C;
            dw_lo_s = GREEN_LO_C;
        end else begin
            dw_hi_s = YELLOW_HI_C;
            dw_lo_s = YELLOW_LO_C;
        end
    end

    // Pick the highest-priority violation for this cycle. The checks are
    // ordered so the first true condition is also the lowest code.
    always_comb begin
        viol_code_s = FC_NONE;
        if (conflict_s) begin
            viol_code_s = FC_CONFLICT;
        end else if (illegal_s) begin
            viol_code_s = FC_ILLEGAL;
        end else if ((state_q != ST_TRACK_FIRST) && (state_q != ST_TRACK)) begin
            viol_code_s = FC_NONE;
        end else if (p_s == phase_q) begin
            if (dwell_cnt_q == dw_hi_s) begin
                viol_code_s = FC_LONG;
            end else begin
                viol_code_s = FC_NONE;
            end
        end else if (p_s != next_phase_s) begin
            viol_code_s = FC_SEQUENCE;
        end else if ((state_q == ST_TRACK) && (dwell_cnt_q < dw_lo_s)) begin
            // Entry alignment is unknown in TRACK_FIRST, so only TRACK
            // checks the short side of the window.
            viol_code_s = FC_SHORT;
        end else begin
            viol_code_s = FC_NONE;
        end
    end

    // Next-state logic for the monitor FSM and all of its registered outputs.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        dwell_cnt_d   = dwell_cnt_q;
        cycle_cnt_d   = cycle_cnt_q;
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_entry_s = 1'b0;

        case (state_q)
            ST_ACQUIRE, ST_TRACK_FIRST, ST_TRACK: begin
                // A new fault beats a simultaneous fault_clr, which is
                // ignored outside FAULT anyway.
                if (viol_code_s != FC_NONE) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    fault_code_d  = viol_code_s;
                    fault_entry_s = 1'b1;
                end else if (state_q == ST_ACQUIRE) begin
                    phase_d     = p_s;
                    dwell_cnt_d = DW_ONE_C;
                    state_d     = ST_TRACK_FIRST;
                end else if (p_s == phase_q) begin
                    if (dwell_cnt_q == DW_MAX_C) begin
                        dwell_cnt_d = dwell_cnt_q;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DW_ONE_C;
                    end
                end else begin
                    // Legal advance to the successor phase.
                    phase_d     = p_s;
                    dwell_cnt_d = DW_ONE_C;
                    state_d     = ST_TRACK;
                    if ((state_q == ST_TRACK) && (phase_q == 2'd3)) begin
                        cycle_cnt_d = cycle_cnt_q + 16'd1;
                    end else begin
                        cycle_cnt_d = cycle_cnt_q;
                    end
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                    state_d      = ST_ACQUIRE;
                end else begin
                    state_d      = ST_FAULT;
                end
            end
            default: begin
                // Unreachable encoding: fall into the fail-safe state.
                state_d       = ST_FAULT;
                fault_d       = 1'b1;
                fault_code_d  = FC_ILLEGAL;
                fault_entry_s = 1'b1;
            end
        endcase

        phase_valid_d = (state_d == ST_TRACK_FIRST) || (state_d == ST_TRACK);
        force_red_d   = fault_d;
    end

`ifdef TRAFFIC_MON_FAULT_CNT_EN
    // Saturating count of FAULT entries; survives fault_clr.
    always_comb begin
        if (fault_entry_s && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end else begin
            fault_cnt_d = fault_cnt_q;
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_ACQUIRE;
            phase_q       <= 2'd0;
            phase_valid_q <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= FC_NONE;
            force_red_q   <= 1'b0;
            cycle_cnt_q   <= 16'd0;
            dwell_cnt_q   <= '0;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
            fault_cnt_q   <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            force_red_q   <= force_red_d;
            cycle_cnt_q   <= cycle_cnt_d;
            dwell_cnt_q   <= dwell_cnt_d;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
            fault_cnt_q   <= fault_cnt_d;
`endif
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign force_red   = force_red_q;
    assign cycle_cnt   = cycle_cnt_q;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    assign fault_cnt   = fault_cnt_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor with GREEN_DWELL=5,
// YELLOW_DWELL=2, TOL=0. Directed scenarios followed by randomized phase
// streams, every cycle compared against a behavioural model.

module tb_traffic_light_monitor;

    localparam int GREEN  = 5;
    localparam int YELLOW = 2;
    localparam int TOLV   = 0;

    logic        clk;
    logic        rst;
    logic [2:0]  ns;
    logic [2:0]  ew;
    logic        fault_clr;
    logic [1:0]  phase;
    logic        phase_valid;
    logic        fault;
    logic [2:0]  fault_code;
    logic        force_red;
    logic [15:0] cycle_cnt;
`ifdef TRAFFIC_MON_FAULT_CNT_EN
    logic [7:0]  fault_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_faulted;
    bit m_locked;   // a phase has been acquired since the last (re)start
    bit m_aligned;  // at least one legal transition seen since acquiring
    int m_phase;
    int m_run;      // consecutive samples of m_phase
    int m_cycles;
    int m_code;
    int m_fcnt;

    traffic_light_monitor #(
        .CNT_W(32),
        .GREEN_DWELL(GREEN),
        .YELLOW_DWELL(YELLOW),
        .TOL(TOLV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ns(ns),
        .ew(ew),
        .fault_clr(fault_clr),
        .phase(phase),
        .phase_valid(phase_valid),
        .fault(fault),
        .fault_code(fault_code),
        .force_red(force_red),
        .cycle_cnt(cycle_cnt)
`ifdef TRAFFIC_MON_FAULT_CNT_EN
        ,
        .fault_cnt(fault_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // -1 = conflict, -2 = illegal, else phase 0..3
    function automatic int classify(input logic [2:0] n, input logic [2:0] e);
        bit n_go, e_go, n_ok, e_ok;
        n_go = (n == 3'b001) || (n == 3'b010);
        e_go = (e == 3'b001) || (e == 3'b010);
        n_ok = n_go || (n == 3'b100);
        e_ok = e_go || (e == 3'b100);
        if (n_go && e_go) return -1;
        if (!n_ok || !e_ok || (!n_go && !e_go)) return -2;
        if (e == 3'b100) return (n == 3'b001) ? 0 : 1;
        return (e == 3'b001) ? 2 : 3;
    endfunction

    function automatic int dwell_of(input int p);
        return (p % 2 == 0) ? GREEN : YELLOW;
    endfunction

    task automatic model_step(input logic [2:0] n, input logic [2:0] e,
                              input logic clr, input logic r);
        int c, viol, lo;
        viol = 0;
        if (r) begin
            m_faulted = 0; m_locked = 0; m_aligned = 0;
            m_phase = 0; m_run = 0; m_cycles = 0; m_code = 0; m_fcnt = 0;
        end else if (m_faulted) begin
            if (clr) begin
                m_faulted = 0; m_code = 0; m_locked = 0; m_aligned = 0;
            end
        end else begin
            c  = classify(n, e);
            lo = dwell_of(m_phase) - TOLV;
            if (lo < 1) lo = 1;
            if (c == -1) viol = 1;
            else if (c == -2) viol = 2;
            else if (!m_locked) begin
                m_phase = c; m_run = 1; m_locked = 1; m_aligned = 0;
            end else if (c == m_phase) begin
                if (m_run == dwell_of(m_phase) + TOLV) viol = 5;
                else m_run++;
            end else if (c != (m_phase + 1) % 4) viol = 3;
            else if (m_aligned && m_run < lo) viol = 4;
            else begin
                if (m_aligned && m_phase == 3) m_cycles = (m_cycles + 1) % 65536;
                m_phase = c; m_run = 1; m_aligned = 1;
            end
            if (viol != 0) begin
                m_faulted = 1; m_code = viol;
                if (m_fcnt < 255) m_fcnt++;
            end
        end
    endtask

    task automatic compare_all();
        check("phase",       32'(phase),       32'(m_phase));
        check("phase_valid", 32'(phase_valid), 32'(m_locked && !m_faulted));
        check("fault",       32'(fault),       32'(m_faulted));
        check("fault_code",  32'(fault_code),  32'(m_code));
        check("force_red",   32'(force_red),   32'(m_faulted));
        check("cycle_cnt",   32'(cycle_cnt),   32'(m_cycles));
`ifdef TRAFFIC_MON_FAULT_CNT_EN
        check("fault_cnt",   32'(fault_cnt),   32'(m_fcnt));
`endif
    endtask

    task automatic drive(input logic [2:0] n, input logic [2:0] e,
                         input logic clr, input logic r);
        @(negedge clk);
        ns = n; ew = e; fault_clr = clr; rst = r;
        @(posedge clk);
        model_step(n, e, clr, r);
        #1;
        compare_all();
    endtask

    task automatic lights(input int p, output logic [2:0] n, output logic [2:0] e);
        case (p)
            0: begin n = 3'b001; e = 3'b100; end
            1: begin n = 3'b010; e = 3'b100; end
            2: begin n = 3'b100; e = 3'b001; end
            default: begin n = 3'b100; e = 3'b010; end
        endcase
    endtask

    task automatic hold(input int p, input int len, input logic clr);
        logic [2:0] n, e;
        lights(p, n, e);
        for (int i = 0; i < len; i++) drive(n, e, clr, 1'b0);
    endtask

    initial begin
        int r, p, len;
        logic clr_b, rst_b;
        logic [2:0] n, e;
        rst = 1'b1; ns = 3'b100; ew = 3'b100; fault_clr = 1'b0;

        // Reset state
        drive(3'b001, 3'b100, 1'b0, 1'b1);
        drive(3'b001, 3'b100, 1'b0, 1'b1);
        check("reset_fault", 32'(fault), 32'd0);
        check("reset_valid", 32'(phase_valid), 32'd0);

        // 1. Legal rotation twice, then re-enter phase 0
        for (int k = 0; k < 2; k++) begin
            hold(0, GREEN, 1'b0); hold(1, YELLOW, 1'b0);
            hold(2, GREEN, 1'b0); hold(3, YELLOW, 1'b0);
        end
        hold(0, 1, 1'b0);
        check("t1_cycles", 32'(cycle_cnt), 32'd2);
        check("t1_fault", 32'(fault), 32'd0);
        check("t1_valid", 32'(phase_valid), 32'd1);
        hold(0, GREEN - 1, 1'b0);

        // 2. Conflict, then illegal input keeps code 1
        drive(3'b001, 3'b010, 1'b0, 1'b0);
        check("t2_code", 32'(fault_code), 32'd1);
        check("t2_force", 32'(force_red), 32'd1);
        drive(3'b111, 3'b000, 1'b0, 1'b0);
        check("t2_code_kept", 32'(fault_code), 32'd1);

        // 3. All-red is illegal; clear, then acquire phase 2
        hold(0, 1, 1'b1);
        check("t3_cleared", 32'(fault), 32'd0);
        drive(3'b100, 3'b100, 1'b0, 1'b0);
        check("t3_code", 32'(fault_code), 32'd2);
        hold(0, 1, 1'b1);
        hold(2, 1, 1'b0);
        check("t3_phase", 32'(phase), 32'd2);
        check("t3_valid", 32'(phase_valid), 32'd1);

        // 4. Skipping a phase is a sequence fault; TRACK_FIRST skips short check
        hold(2, GREEN - 1, 1'b0); hold(3, YELLOW, 1'b0); hold(0, GREEN, 1'b0);
        hold(2, 1, 1'b0);
        check("t4_code", 32'(fault_code), 32'd3);
        hold(1, 1, 1'b1);
        hold(1, 1, 1'b0);
        hold(2, 1, 1'b0);
        check("t4_first_ok", 32'(fault), 32'd0);
        check("t4_phase", 32'(phase), 32'd2);

        // 5. Dwell short, then dwell long
        hold(2, GREEN - 1, 1'b0); hold(3, YELLOW, 1'b0);
        hold(0, GREEN - 1, 1'b0); hold(1, 1, 1'b0);
        check("t5_short", 32'(fault_code), 32'd4);
        hold(0, 1, 1'b1);
        hold(0, GREEN, 1'b0);
        check("t5_at_limit", 32'(fault), 32'd0);
        hold(0, 1, 1'b0);
        check("t5_long", 32'(fault_code), 32'd5);

        // 6. Clear colliding with a conflict, then reset mid-FAULT
        hold(0, 1, 1'b1);
        hold(0, GREEN, 1'b0); hold(1, 1, 1'b0);
        drive(3'b001, 3'b010, 1'b1, 1'b0);
        check("t6_fault", 32'(fault), 32'd1);
        check("t6_code", 32'(fault_code), 32'd1);
`ifdef TRAFFIC_MON_FAULT_CNT_EN
        check("t6_fcnt", 32'(fault_cnt), 32'd6);
`endif
        drive(3'b010, 3'b100, 1'b0, 1'b1);
        check("t6_rst_fault", 32'(fault), 32'd0);
        check("t6_rst_code", 32'(fault_code), 32'd0);
        check("t6_rst_cycles", 32'(cycle_cnt), 32'd0);
`ifdef TRAFFIC_MON_FAULT_CNT_EN
        check("t6_rst_fcnt", 32'(fault_cnt), 32'd0);
`endif

        // Randomized phase streams with glitches, jumps, clears and resets
        p = 0;
        for (int seg = 0; seg < 400; seg++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                n = 3'($urandom_range(0, 7));
                e = 3'($urandom_range(0, 7));
                drive(n, e, 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                if (r < 12) p = int'($urandom_range(0, 3));
                else p = (p + 1) % 4;
                len = dwell_of(p) + int'($urandom_range(0, 2)) - 1;
                if (r > 90) len = len + int'($urandom_range(0, 2));
                if (len < 1) len = 1;
                lights(p, n, e);
                for (int i = 0; i < len; i++) begin
                    clr_b = ($urandom_range(0, 11) == 0);
                    rst_b = ($urandom_range(0, 299) == 0);
                    drive(n, e, clr_b, rst_b);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
